note_player: RTL and testbench

- Consumer end of the note handshake driven by the song reader.
- Accepts a one-cycle new_note strobe carrying note/duration, holds the note for duration beats, then returns a one-cycle note_done pulse.
- While the note sounds, advances a 20-bit phase accumulator by the frequency-ROM step size on every sample request; this phase feeds the sine/sample generator.
- Pauses cleanly with play.

---
 rtl/note_player.sv | 82 ++++++++
 tb/tb_note_player.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// Note player: latches a note/duration from the song reader, counts beats while playing,
// advances the sine phase accumulator on sample requests, and pulses note_done on expiry.
module note_player #(
  parameter int NOTE_WIDTH     = 6,
  parameter int DURATION_WIDTH = 6,
  parameter int PHASE_WIDTH    = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      new_note,
  input  logic [NOTE_WIDTH-1:0]     note,
  input  logic [DURATION_WIDTH-1:0] duration,
  input  logic                      beat,
  input  logic                      generate_next_sample,
  input  logic [PHASE_WIDTH-1:0]    step_size,
  output logic [NOTE_WIDTH-1:0]     note_out,
  output logic                      playing,
  output logic [PHASE_WIDTH-1:0]    phase,
  output logic                      note_done
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

  state_e                    state_q, state_d;
  logic [NOTE_WIDTH-1:0]     note_q, note_d;
  logic [DURATION_WIDTH-1:0] remaining_q, remaining_d;
  logic [PHASE_WIDTH-1:0]    phase_q, phase_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      note_q      <= '0;
      remaining_q <= '0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      note_q      <= note_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    note_d      = note_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;

    if (new_note) begin
      // A new note overrides everything, including a beat or sample in the same cycle.
      note_d      = note;
      remaining_d = duration;
      phase_d     = '0;
      state_d     = (duration == '0) ? DONE : PLAY;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (play) begin
            if (beat) begin
              remaining_d = remaining_q - DURATION_WIDTH'(1);
              if (remaining_q == DURATION_WIDTH'(1)) state_d = DONE;
            end
            // Rests keep the phase parked at zero so the sine generator stays silent.
            if (generate_next_sample && note_q != '0) phase_d = phase_q + step_size;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign note_out  = note_q;
  assign phase     = phase_q;
  assign note_done = (state_q == DONE);
  assign playing   = (state_q == PLAY) && play && (note_q != '0);

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: cycle vector table through a scoreboard queue,
// plus hand-written sequences for beat timing, pause, and asynchronous reset.
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        beat;
  logic        generate_next_sample;
  logic [19:0] step_size;
  logic [5:0]  note_out;
  logic        playing;
  logic [19:0] phase;
  logic        note_done;

  int checks = 0;
  int errors = 0;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .new_note             (new_note),
    .note                 (note),
    .duration             (duration),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .step_size            (step_size),
    .note_out             (note_out),
    .playing              (playing),
    .phase                (phase),
    .note_done            (note_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nn;
    logic [5:0]  note;
    logic [5:0]  dur;
    logic        beat;
    logic        gen;
    logic        play;
    logic [19:0] step;
    logic [5:0]  exp_note;
    logic        exp_playing;
    logic [19:0] exp_phase;
    logic        exp_done;
  } vec_t;

  typedef struct {
    int          idx;
    logic [5:0]  note;
    logic        playing;
    logic [19:0] phase;
    logic        done;
  } exp_t;

  vec_t vecs[23];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nn, input logic [5:0] n, input logic [5:0] d,
                       input logic b, input logic g, input logic p, input logic [19:0] s);
    new_note = nn; note = n; duration = d; beat = b;
    generate_next_sample = g; play = p; step_size = s;
  endtask

  function automatic vec_t mk(logic nn, logic [5:0] n, logic [5:0] d, logic b, logic g,
                              logic p, logic [19:0] s, logic [5:0] en, logic ep,
                              logic [19:0] eph, logic ed);
    vec_t v;
    v.nn = nn; v.note = n; v.dur = d; v.beat = b; v.gen = g; v.play = p; v.step = s;
    v.exp_note = en; v.exp_playing = ep; v.exp_phase = eph; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    int done_cnt;
    int done_cyc;
    bit playing_seen;

    // Each row: inputs held across one edge, then outputs expected just after it.
    vecs[0]  = mk(1, 20, 2, 1, 1, 1, 20'h00100, 20, 1, 20'h00000, 0); // beat with new_note ignored
    vecs[1]  = mk(0,  0, 0, 0, 1, 1, 20'h00100, 20, 1, 20'h00100, 0);
    vecs[2]  = mk(0,  0, 0, 1, 0, 1, 20'h00100, 20, 1, 20'h00100, 0);
    vecs[3]  = mk(0,  0, 0, 0, 1, 1, 20'h00100, 20, 1, 20'h00200, 0);
    vecs[4]  = mk(0,  0, 0, 1, 1, 1, 20'h00100, 20, 0, 20'h00300, 1);
    vecs[5]  = mk(0,  0, 0, 0, 0, 1, 20'h00100, 20, 0, 20'h00300, 0);
    vecs[6]  = mk(0,  0, 0, 0, 1, 1, 20'h00100, 20, 0, 20'h00300, 0); // idle holds phase
    vecs[7]  = mk(1,  7, 0, 0, 0, 1, 20'h00100,  7, 0, 20'h00000, 1); // zero duration
    vecs[8]  = mk(1,  3, 1, 0, 0, 1, 20'h00100,  3, 1, 20'h00000, 0); // new_note during DONE
    vecs[9]  = mk(0,  0, 0, 1, 0, 1, 20'h00100,  3, 0, 20'h00000, 1);
    vecs[10] = mk(0,  0, 0, 0, 0, 1, 20'h00100,  3, 0, 20'h00000, 0);
    vecs[11] = mk(1,  0, 2, 0, 0, 1, 20'h00100,  0, 0, 20'h00000, 0); // rest
    vecs[12] = mk(0,  0, 0, 1, 1, 1, 20'h00555,  0, 0, 20'h00000, 0);
    vecs[13] = mk(0,  0, 0, 1, 1, 1, 20'h00555,  0, 0, 20'h00000, 1);
    vecs[14] = mk(0,  0, 0, 0, 0, 1, 20'h00000,  0, 0, 20'h00000, 0);
    vecs[15] = mk(1,  9, 5, 0, 0, 1, 20'h00000,  9, 1, 20'h00000, 0);
    vecs[16] = mk(0,  0, 0, 0, 1, 1, 20'hFFE00,  9, 1, 20'hFFE00, 0);
    vecs[17] = mk(0,  0, 0, 0, 1, 1, 20'h00400,  9, 1, 20'h00200, 0); // wrap
    vecs[18] = mk(0,  0, 0, 1, 0, 1, 20'h00000,  9, 1, 20'h00200, 0);
    vecs[19] = mk(1,  5, 1, 1, 0, 1, 20'h00000,  5, 1, 20'h00000, 0); // abort, beat ignored
    vecs[20] = mk(0,  0, 0, 0, 0, 1, 20'h00000,  5, 1, 20'h00000, 0);
    vecs[21] = mk(0,  0, 0, 1, 0, 1, 20'h00000,  5, 0, 20'h00000, 1);
    vecs[22] = mk(0,  0, 0, 0, 0, 1, 20'h00000,  5, 0, 20'h00000, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 20'h0);
    #12;
    check("reset_note_out", 32'(note_out), 32'd0);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_playing", 32'(playing), 32'd0);
    check("reset_done", 32'(note_done), 32'd0);
    #2 reset = 1'b0;
    tick();

    for (int i = 0; i < 23; i++) begin
      exp_t e;
      drive(vecs[i].nn, vecs[i].note, vecs[i].dur, vecs[i].beat, vecs[i].gen,
            vecs[i].play, vecs[i].step);
      e.idx = i; e.note = vecs[i].exp_note; e.playing = vecs[i].exp_playing;
      e.phase = vecs[i].exp_phase; e.done = vecs[i].exp_done;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      check($sformatf("vec%0d_note_out", e.idx), 32'(note_out), 32'(e.note));
      check($sformatf("vec%0d_playing", e.idx), 32'(playing), 32'(e.playing));
      check($sformatf("vec%0d_phase", e.idx), 32'(phase), 32'(e.phase));
      check($sformatf("vec%0d_done", e.idx), 32'(note_done), 32'(e.done));
    end
    drive(0, 0, 0, 0, 0, 1, 20'h0);
    tick();

    // Note 20 for 3 beats spaced 8 cycles apart, five samples at step 0x400.
    drive(1, 20, 3, 0, 0, 1, 20'h00400);
    tick();
    check("seq_note_out", 32'(note_out), 32'd20);
    check("seq_playing", 32'(playing), 32'd1);
    new_note = 1'b0;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      beat = (c % 8 == 0);
      generate_next_sample = (c <= 5);
      tick();
      if (note_done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    beat = 1'b0;
    generate_next_sample = 1'b0;
    check("seq_done_count", 32'(done_cnt), 32'd1);
    check("seq_done_cycle", 32'(done_cyc), 32'd24);
    check("seq_phase", 32'(phase), 32'h01400);
    check("seq_idle_playing", 32'(playing), 32'd0);

    // Pause after the first of four beats; beats and samples while paused must not count.
    drive(1, 12, 4, 0, 0, 1, 20'h00010);
    tick();
    drive(0, 0, 0, 1, 1, 1, 20'h00010);
    tick();
    check("pause_pre_phase", 32'(phase), 32'h00010);
    drive(0, 0, 0, 0, 0, 0, 20'h00010);
    done_cnt = 0;
    playing_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat = (i % 2 == 0);
      generate_next_sample = (i % 2 == 1);
      tick();
      if (note_done) done_cnt++;
      if (playing) playing_seen = 1'b1;
    end
    check("pause_phase", 32'(phase), 32'h00010);
    check("pause_playing", 32'(playing_seen), 32'd0);
    check("pause_done", 32'(done_cnt), 32'd0);
    drive(0, 0, 0, 0, 0, 1, 20'h00010);
    tick();
    check("resume_playing", 32'(playing), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      check($sformatf("resume_beat%0d_done", k), 32'(note_done), (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    check("resume_idle_done", 32'(note_done), 32'd0);

    // Asynchronous reset in the middle of a sounding note.
    drive(1, 33, 9, 0, 0, 1, 20'h00123);
    tick();
    drive(0, 0, 0, 0, 1, 1, 20'h00123);
    tick();
    generate_next_sample = 1'b0;
    check("areset_pre_phase", 32'(phase), 32'h00123);
    #2 reset = 1'b1;
    #1;
    check("areset_note_out", 32'(note_out), 32'd0);
    check("areset_phase", 32'(phase), 32'd0);
    check("areset_playing", 32'(playing), 32'd0);
    check("areset_done", 32'(note_done), 32'd0);
    #2 reset = 1'b0;
    tick();
    check("areset_after_done", 32'(note_done), 32'd0);
    check("areset_after_note", 32'(note_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
